// File: rtl/rpn_stack_alu.sv
// rpn_stack_alu: RPN evaluation stack with ALU; TOS in a register, lower entries in a sync-read array.
// Define RPN_MUL_EN to build the multiplier; otherwise MUL reports illegal.
module rpn_stack_alu #(
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              cmd_valid,
  input  logic [2:0]        cmd_op,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              cmd_ready,
  output logic [DATA_W-1:0] top,
  output logic [AW:0]       depth,
  output logic              empty,
  output logic              full,
  output logic [2:0]        err
);
  localparam logic [2:0] OP_PUSH = 3'd0, OP_POP = 3'd1, OP_ADD = 3'd2, OP_SUB = 3'd3,
                         OP_MUL = 3'd4, OP_DUP = 3'd5, OP_SWAP = 3'd6, OP_CLR = 3'd7;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH-1];
  logic [DATA_W-1:0] rd_data, res;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [2:0] op_q;
  logic accept, few, ovf, unf, ill, bad, nos_op, wr_en;
`ifdef RPN_MUL_EN
  logic [2*DATA_W-1:0] prod;
`endif
  assign cmd_ready = state == S_IDLE;
  assign empty = depth == '0;
  assign full = depth == (AW+1)'(DEPTH);
  always_comb begin
    accept = cmd_valid && state == S_IDLE;
    few = depth < (AW+1)'(2);
    ovf = (cmd_op == OP_PUSH || cmd_op == OP_DUP) && full;
    unf = ((cmd_op == OP_POP || cmd_op == OP_DUP) && empty) ||
          ((cmd_op == OP_ADD || cmd_op == OP_SUB || cmd_op == OP_MUL || cmd_op == OP_SWAP) && few);
`ifdef RPN_MUL_EN
    ill = 1'b0;
    prod = rd_data * top;
`else
    ill = cmd_op == OP_MUL && !unf;
`endif
    bad = ovf || unf || ill;
    nos_op = cmd_op inside {OP_POP, OP_ADD, OP_SUB, OP_MUL, OP_SWAP};
    state_nx = state == S_IDLE ? ((accept && !bad && nos_op) ? S_FETCH : S_IDLE) :
               state == S_FETCH ? S_EXEC : S_IDLE;
    res = op_q == OP_ADD ? rd_data + top :
          op_q == OP_SUB ? rd_data - top :
`ifdef RPN_MUL_EN
          op_q == OP_MUL ? prod[DATA_W-1:0] :
`endif
          (op_q == OP_POP && depth == (AW+1)'(1)) ? '0 : rd_data;
    wr_en = (accept && !bad && (cmd_op == OP_PUSH || cmd_op == OP_DUP) && !empty) ||
            (state == S_EXEC && op_q == OP_SWAP);
    wr_addr = state == S_EXEC ? rd_addr : AW'(depth - (AW+1)'(1));
  end
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
      top <= '0;
      depth <= '0;
      err <= '0;
      op_q <= OP_PUSH;
      rd_addr <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= cmd_op;
        rd_addr <= few ? '0 : AW'(depth - (AW+1)'(2));
        if (bad) err <= err | {ill, unf, ovf};
        else if (cmd_op == OP_PUSH) begin
          top <= cmd_data;
          depth <= depth + 1'b1;
        end else if (cmd_op == OP_DUP) depth <= depth + 1'b1;
        else if (cmd_op == OP_CLR) begin
          top <= '0;
          depth <= '0;
          err <= '0;
        end
      end
      if (state == S_EXEC) begin
        top <= res;
        if (op_q != OP_SWAP) depth <= depth - 1'b1;
      end
    end
  end
  // Array has no reset: contents at or above depth-1 are never observed.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en) mem[wr_addr] <= top;
    rd_data <= mem[rd_addr];
  end
endmodule

// File: tb/tb_rpn_stack_alu.sv
// tb_rpn_stack_alu: random and directed commands against a queue-based stack model.
module tb_rpn_stack_alu;
  logic clk = 0, reset_n = 0, cmd_valid = 0;
  logic [2:0] cmd_op = 0;
  logic [7:0] cmd_data = 0;
  logic cmd_ready, empty, full;
  logic [7:0] top;
  logic [2:0] depth, err;
  int n_vec = 0, n_bad = 0;
  logic [7:0] stk[$];
  logic [2:0] m_err = 0;
  always #5 clk = ~clk;
  rpn_stack_alu #(.DATA_W(8), .DEPTH(4)) dut (
    .CLOCK_50(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_ready(cmd_ready), .top(top), .depth(depth),
    .empty(empty), .full(full), .err(err)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic check_state();
    logic [7:0] exp_top;
    exp_top = stk.size() != 0 ? stk[$] : 8'd0;
    check("top", top, exp_top);
    check("depth", depth, stk.size());
    check("empty", empty, stk.size() == 0);
    check("full", full, stk.size() == 4);
    check("err", err, m_err);
  endtask
  task automatic cmd(input logic [2:0] op, input logic [7:0] d);
    int n;
    bit ovf, unf, ill, multi;
    logic [7:0] a, b;
    n = stk.size();
    ovf = (op == 0 || op == 5) && n == 4;
    unf = ((op == 1 || op == 5) && n == 0) || ((op == 2 || op == 3 || op == 4 || op == 6) && n < 2);
`ifdef RPN_MUL_EN
    ill = 0;
`else
    ill = op == 4 && !unf;
`endif
    multi = !(ovf || unf || ill) && (op inside {1, 2, 3, 4, 6});
    @(negedge clk);
    check("ready_pre", cmd_ready, 1);
    cmd_valid = 1;
    cmd_op = op;
    cmd_data = d;
    @(posedge clk);
    #1 cmd_valid = 0;
    cmd_op = 3'($urandom);
    cmd_data = 8'($urandom);
    if (multi) begin
      check("busy1", cmd_ready, 0);
      @(posedge clk);
      #1 check("busy2", cmd_ready, 0);
      @(posedge clk);
      #1;
    end
    if (ovf || unf || ill) m_err = m_err | {ill, unf, ovf};
    else case (op)
      0: stk.push_back(d);
      1: void'(stk.pop_back());
      2: begin a = stk.pop_back(); b = stk.pop_back(); stk.push_back(b + a); end
      3: begin a = stk.pop_back(); b = stk.pop_back(); stk.push_back(b - a); end
      4: begin a = stk.pop_back(); b = stk.pop_back(); stk.push_back(b * a); end
      5: stk.push_back(stk[$]);
      6: begin a = stk.pop_back(); b = stk.pop_back(); stk.push_back(a); stk.push_back(b); end
      default: begin stk.delete(); m_err = 0; end
    endcase
    check_state();
  endtask
  initial begin
    logic [2:0] op;
    repeat (3) @(posedge clk);
    #1 check("rst_ready", cmd_ready, 1);
    check_state();
    @(negedge clk) reset_n = 1;
    cmd(0, 3); cmd(0, 4); cmd(2, 0);
    check("t1_top", top, 7);
    check("t1_depth", depth, 1);
    check("t1_err", err, 0);
    cmd(7, 0);
    cmd(0, 2); cmd(0, 5); cmd(3, 0);
    check("t2_sub", top, 8'hFD);
    cmd(0, 8'hFF); cmd(2, 0);
    check("t2_add", top, 8'hFC);
    cmd(7, 0);
    cmd(0, 1); cmd(0, 2); cmd(0, 3); cmd(0, 4);
    check("t3_full", full, 1);
    cmd(0, 9);
    check("t3_err", err, 3'b001);
    check("t3_top", top, 4);
    check("t3_depth", depth, 4);
    cmd(7, 0);
    check("t3_clr_err", err, 0);
    check("t3_clr_empty", empty, 1);
    cmd(1, 0);
    check("t4_pop_err", err, 3'b010);
    cmd(0, 7); cmd(2, 0);
    check("t4_add_err", err, 3'b010);
    check("t4_top", top, 7);
    cmd(7, 0);
    cmd(0, 8'h10); cmd(0, 8'h11); cmd(4, 0);
`ifdef RPN_MUL_EN
    check("t5_top", top, 8'h10);
    check("t5_depth", depth, 1);
`else
    check("t5_err", err, 3'b100);
    check("t5_top", top, 8'h11);
    check("t5_depth", depth, 2);
`endif
    cmd(7, 0);
    cmd(0, 1); cmd(0, 2); cmd(6, 0);
    check("t6_swap", top, 1);
    cmd(1, 0);
    check("t6_pop", top, 2);
    @(negedge clk);
    cmd_valid = 1;
    cmd_op = 1;
    @(posedge clk);
    #1 cmd_valid = 0;
    check("t6_fetch", cmd_ready, 0);
    reset_n = 0;
    #1 check("t6_abort_ready", cmd_ready, 1);
    check("t6_abort_top", top, 0);
    check("t6_abort_depth", depth, 0);
    stk.delete();
    m_err = 0;
    @(negedge clk) reset_n = 1;
    repeat (400) begin
      op = 3'($urandom_range(0, 7));
      if (op == 7 && $urandom_range(0, 3) != 0) op = 0;
      cmd(op, 8'($urandom));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/rpn_stack_alu.md
# rpn_stack_alu

Parametrised RPN evaluation stack with an integrated ALU. It is the successor to the board-level stack-pointer register. It holds top-of-stack (TOS) in a register and the lower entries in a synchronous-read array, and executes push/pop/arithmetic/stack-manipulation commands over a valid/ready handshake. It sits between the key/switch input decoder and the HEX/LED display logic of the calculator, and reports depth, full/empty and sticky error status.

## Interface
- DATA_W, 8: operand width in bits; all arithmetic is modulo 2^DATA_W.
- DEPTH, 16: total entry capacity including TOS; power of two, ≥ 2. AW = clog2(DEPTH) is a derived localparam.
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_op  in  3  opcode: 000 PUSH, 001 POP, 010 ADD, 011 SUB, 100 MUL, 101 DUP, 110 SWAP, 111 CLR.
- cmd_data  in  DATA_W  operand for PUSH; ignored otherwise.
- cmd_ready  out  1  block can accept a command; high only in S_IDLE.
- top  out  DATA_W  current TOS; 0 when empty.
- depth  out  AW+1  number of valid entries, 0..DEPTH.
- empty  out  1  depth == 0.
- full  out  1  depth == DEPTH.
- err  out  3  sticky {illegal, underflow, overflow}.

## Operation
- A command is accepted on a rising edge with cmd_valid && cmd_ready. Inputs are sampled only at acceptance.
- Entries below TOS live in mem[0..DEPTH-2]. The next-on-stack (NOS) entry is at mem[depth-2].
- FSM states are S_IDLE, S_FETCH and S_EXEC.
- **Single-cycle ops (PUSH, DUP, CLR, and any errored op):** complete at acceptance and stay in S_IDLE.
  - PUSH: mem[depth-1] <= TOS when depth ≥ 1; TOS <= cmd_data; depth++.
  - DUP: same as PUSH, with TOS unchanged.
  - CLR: depth <= 0, TOS <= 0, err <= 0.
- **NOS ops (POP, ADD, SUB, MUL, SWAP):** path is S_IDLE -> S_FETCH (read address mem[depth-2] registered) -> S_EXEC (read data valid; update) -> S_IDLE.
  - POP: TOS <= NOS, depth--. When depth == 1, TOS <= 0 and depth <= 0, with no read used.
  - ADD: TOS <= NOS + TOS, depth--.
  - SUB: TOS <= NOS − TOS, depth--.
  - MUL: TOS <= low DATA_W bits of NOS × TOS, depth--.
  - SWAP: TOS <= NOS, mem[depth-2] <= old TOS; depth unchanged.
- **Error checks at acceptance.** An errored command changes nothing except err.
  - Overflow, err[0]: PUSH or DUP when full.
  - Underflow, err[1]: POP or DUP when empty; ADD, SUB, MUL or SWAP when depth < 2.
  - Illegal, err[2]: see Configuration.
- err bits are sticky OR-accumulated. They clear only on CLR or reset.
- Array contents are never cleared. Entries at or above depth-1 are don't-care.

## Timing
- **Reset (reset_n low, asynchronous):** state S_IDLE, cmd_ready=1, top=0, depth=0, empty=1, full=0, err=000, all held while reset_n is low.
- **Reset mid-operation** (in S_FETCH or S_EXEC) aborts the command with no write. cmd_ready is 1 immediately.
- **Single-cycle op:** top, depth, flags and err are updated on the acceptance edge. cmd_ready stays high, giving back-to-back throughput of 1 per cycle.
- **NOS op:** cmd_ready is low for exactly 2 cycles after the acceptance edge. Results appear on the edge that leaves S_EXEC, 3 edges after acceptance counting the acceptance edge as 1.
- Status outputs are registered. empty and full are decoded from the registered depth.
- **Wrap-around:** ADD, SUB and MUL wrap modulo 2^DATA_W with no carry or borrow flag.

## Configuration
- RPN_MUL_EN defined: MUL is implemented as above, using one DATA_W×DATA_W multiplier.
- RPN_MUL_EN undefined: no multiplier is synthesised. MUL sets err[2] at acceptance, completes in 1 cycle, and leaves the stack unchanged. The underflow check still has priority, so MUL with depth < 2 sets err[1] only.

## Test plan
All scenarios use DATA_W=8, DEPTH=4.
1. Reset; PUSH 3, PUSH 4, ADD -> cmd_ready low exactly 2 cycles; then top=7, depth=1, err=000.
2. PUSH 2, PUSH 5, SUB -> top=0xFD, depth=1. PUSH 0xFF, ADD -> top=0xFC.
3. PUSH 1,2,3,4 back-to-back -> full=1, top=4. PUSH 9 -> err=001, top=4, depth=4. CLR -> depth=0, empty=1, top=0, err=000.
4. Empty: POP -> err=010, depth=0. PUSH 7, ADD -> err=010, top=7, depth=1.
5. PUSH 0x10, PUSH 0x11, MUL:
   - With RPN_MUL_EN: top=0x10, depth=1.
   - Without RPN_MUL_EN: err=100, top=0x11, depth=2.
6. PUSH 1, PUSH 2, SWAP -> top=1, depth=2. POP -> top=2, depth=1. Start POP, drop reset_n during S_FETCH -> top=0, depth=0, cmd_ready=1 immediately.
